// File: rtl/mac_driver.sv
// mac_driver: buffers upstream operand pairs and feeds them to a MAC.
// It then returns the settled accumulator value as a single result beat.
// Optional issue watchdog: define MAC_DRIVER_TIMEOUT_EN.
module mac_driver #(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode_int,
   input  logic [7:0]  len,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        mac_float_int,
   output logic        mac_en,
   output logic        mac_data_en,
   output logic [15:0] mac_data_a,
   output logic [15:0] mac_data_b,
   input  logic        mac_over,
   input  logic [31:0] mac_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_err,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, RESULT} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [7:0]    len_q, len_d, acc_cnt_q, acc_cnt_d, iss_cnt_q, iss_cnt_d;
   logic          mode_q, mode_d;
   logic [31:0]   res_data_q, res_data_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [31:0]   head;
   logic          start_job, empty, full, push, pop, last_issue, timeout;

   assign start_job  = (state_q == IDLE) && start;
   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign push       = op_valid && op_ready;
   assign pop        = (state_q == RUN) && !empty;
   assign last_issue = pop && (iss_cnt_q == len_q - 8'd1);
   assign head       = mem_q[rd_ptr_q];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state decode; a watchdog abort leaves RUN the same way as the last issue
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? CLEAR : IDLE;
         CLEAR:   state_d = (len_q != 8'd0) ? RUN : SETTLE;
         RUN:     state_d = (last_issue || timeout) ? SETTLE : RUN;
         SETTLE:  state_d = mac_over ? RESULT : SETTLE;
         RESULT:  state_d = res_ready ? IDLE : RESULT;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state and buffer occupancy
   always_comb begin
      busy          = (state_q != IDLE);
      mac_en        = (state_q == RUN) || (state_q == SETTLE);
      mac_data_en   = pop;
      mac_data_a    = pop ? head[31:16] : 16'd0;
      mac_data_b    = pop ? head[15:0]  : 16'd0;
      mac_float_int = (state_q == IDLE) ? 1'b1 : mode_q;
      res_valid     = (state_q == RESULT);
      res_data      = res_data_q;
      op_ready      = ((state_q == CLEAR) || (state_q == RUN)) && !full && (acc_cnt_q < len_q);
   end

   // job bookkeeping and buffer pointers; a new job flushes anything left by an aborted one
   always_comb begin
      len_d      = start_job ? len : len_q;
      mode_d     = start_job ? mode_int : mode_q;
      acc_cnt_d  = start_job ? 8'd0 : acc_cnt_q + 8'(push);
      iss_cnt_d  = start_job ? 8'd0 : iss_cnt_q + 8'(pop);
      wr_ptr_d   = start_job ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d   = start_job ? '0 : rd_ptr_q + AW'(pop);
      cnt_d      = start_job ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      res_data_d = (state_q == SETTLE && mac_over) ? ((len_q == 8'd0) ? 32'd0 : mac_out) : res_data_q;
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= 8'd0;
         mode_q     <= 1'b0;
         acc_cnt_q  <= 8'd0;
         iss_cnt_q  <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         res_data_q <= 32'd0;
      end else begin
         len_q      <= len_d;
         mode_q     <= mode_d;
         acc_cnt_q  <= acc_cnt_d;
         iss_cnt_q  <= iss_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         res_data_q <= res_data_d;
      end
   end

   // operand storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {op_a, op_b};
   end

`ifdef MAC_DRIVER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          res_err_q, res_err_d;

   // watchdog counts consecutive RUN cycles without an issue
   always_comb begin
      wd_d      = (state_q == RUN && !pop) ? wd_q + WW'(1) : '0;
      timeout   = (state_q == RUN) && !pop && (wd_q == WW'(TIMEOUT_CYC - 1));
      res_err_d = start_job ? 1'b0 : (timeout ? 1'b1 : res_err_q);
   end

   // watchdog registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q      <= '0;
         res_err_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         res_err_q <= res_err_d;
      end
   end

   assign res_err = res_err_q;
`else
   assign timeout = 1'b0;
   assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_mac_driver.sv
// tb_mac_driver: directed and random jobs against a behavioural MAC and a queue-based result model.
module tb_mac_driver;
   logic        clk = 0, rst_n = 0, start = 0, mode_int = 0, op_valid = 0, res_ready = 0;
   logic [7:0]  len = 0;
   logic [15:0] op_a = 0, op_b = 0;
   logic        op_ready, mac_float_int, mac_en, mac_data_en, mac_over, res_valid, res_err, busy;
   logic [15:0] mac_data_a, mac_data_b;
   logic [31:0] mac_out, res_data;

   mac_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_int(mode_int), .len(len),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .mac_float_int(mac_float_int), .mac_en(mac_en), .mac_data_en(mac_data_en),
      .mac_data_a(mac_data_a), .mac_data_b(mac_data_b), .mac_over(mac_over), .mac_out(mac_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // external MAC: clears when disabled, accumulates a*b (int) or the raw pair word (float stand-in)
   logic [31:0] macc;
   logic        over_r;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         macc   <= 0;
         over_r <= 0;
      end else begin
         over_r <= mac_en && !mac_data_en;
         if (!mac_en) macc <= 0;
         else if (mac_data_en)
            macc <= macc + (mac_float_int ? {16'd0, mac_data_a} * {16'd0, mac_data_b} : {mac_data_a, mac_data_b});
      end
   end
   assign mac_out  = macc;
   assign mac_over = over_r;

   int checks = 0, passes = 0, fails = 0, cyc = 0;
   logic [31:0] src[$], acc_q[$], iss[$];
   int iss_cyc[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issue monitor
   always @(negedge clk) begin
      if (mac_data_en) begin
         iss.push_back({mac_data_a, mac_data_b});
         iss_cyc.push_back(cyc);
      end else if (rst_n) chk("data_zero_when_idle", {mac_data_a, mac_data_b}, 32'd0);
   end

   function automatic logic [31:0] model(input logic m, input int n);
      logic [31:0] s = 0;
      for (int i = 0; i < n && i < acc_q.size(); i++)
         s += m ? {16'd0, acc_q[i][31:16]} * {16'd0, acc_q[i][15:0]} : acc_q[i];
      return s;
   endfunction

   // vmode: 0 random valid, 1 always valid, 2 alternate, 3 stop after first accept
   task automatic job(input logic m, input int n, input int vmode, input int hold, input bit poke,
                      output logic [31:0] rd, output logic re);
      int k = 0;
      int t = 0;
      acc_q.delete();
      iss.delete();
      iss_cyc.delete();
      @(negedge clk);
      start = 1; mode_int = m; len = 8'(n);
      @(negedge clk);
      start = 0; mode_int = ~m; len = 8'($urandom);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("mode_latched", {31'd0, mac_float_int}, {31'd0, m});
      while (!res_valid && t < 2000) begin
         op_valid = vmode == 1 ? 1'b1 : vmode == 2 ? t[0] : vmode == 3 ? (acc_q.size() == 0) : 1'($urandom_range(0, 1));
         op_a = k < src.size() ? src[k][31:16] : 16'($urandom);
         op_b = k < src.size() ? src[k][15:0]  : 16'($urandom);
         if (op_valid && op_ready) begin
            acc_q.push_back({op_a, op_b});
            k++;
         end
         @(negedge clk);
         t++;
      end
      op_valid = 0;
      rd = res_data;
      re = res_err;
      chk("result_reached", {31'd0, res_valid}, 32'd1);
      if (poke) begin
         start = 1;
         @(negedge clk);
         start = 0;
         chk("start_ignored_in_result", {31'd0, res_valid}, 32'd1);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("res_data_stable", res_data, rd);
         chk("res_valid_held", {31'd0, res_valid}, 32'd1);
      end
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
      chk("idle_after_handshake", {31'd0, busy}, 32'd0);
      chk("mode_one_in_idle", {31'd0, mac_float_int}, 32'd1);
   endtask

   task automatic post(input int n);
      chk("accept_count", 32'(acc_q.size()), 32'(n));
      chk("issue_count", 32'(iss.size()), 32'(n));
      for (int i = 0; i < n && i < iss.size() && i < acc_q.size(); i++)
         chk("issue_order", iss[i], acc_q[i]);
   endtask

   initial begin
      logic [31:0] rd;
      logic re;
      int k;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mode", {31'd0, mac_float_int}, 32'd1);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_outs", {26'd0, res_err, res_valid, op_ready, mac_en, mac_data_en, busy}, 32'd0);
      rst_n = 1;
      repeat (3) @(negedge clk);
      chk("no_spurious_start", {31'd0, busy}, 32'd0);

      src = '{{16'd2, 16'd3}, {16'd4, 16'd5}, {16'd1, 16'd1}};
      job(1, 3, 0, 1, 0, rd, re);
      chk("int_result", rd, 32'd27);
      chk("int_err", {31'd0, re}, 32'd0);
      post(3);

      src = '{{16'h3c00, 16'h4000}, {16'hc100, 16'h3555}};
      job(0, 2, 2, 0, 0, rd, re);
      chk("float_result", rd, model(0, 2));
      post(2);

      src.delete();
      for (int i = 0; i < 5; i++) src.push_back($urandom);
      job(1, 5, 1, 10, 0, rd, re);
      chk("len5_result", rd, model(1, 5));
      post(5);
      chk("one_issue_per_cycle", 32'(iss_cyc.size() >= 5 ? iss_cyc[4] - iss_cyc[0] : -1), 32'd4);

      job(1, 0, 1, 2, 1, rd, re);
      chk("len0_result", rd, 32'd0);
      chk("len0_err", {31'd0, re}, 32'd0);
      post(0);

      for (int j = 0; j < 4; j++) begin
         int n;
         logic m;
         n = $urandom_range(1, 12);
         m = 1'($urandom_range(0, 1));
         src.delete();
         for (int i = 0; i < n; i++) src.push_back($urandom);
         job(m, n, 0, $urandom_range(0, 3), 0, rd, re);
         chk("rand_result", rd, model(m, n));
         chk("rand_err", {31'd0, re}, 32'd0);
         post(n);
      end

      src.delete();
      for (int i = 0; i < 4; i++) src.push_back($urandom);
      iss.delete();
      @(negedge clk);
      start = 1; mode_int = 1; len = 8'd4;
      @(negedge clk);
      start = 0;
      k = 0;
      for (int t = 0; t < 50 && iss.size() < 2; t++) begin
         op_valid = 1;
         op_a = k < 4 ? src[k][31:16] : 16'd0;
         op_b = k < 4 ? src[k][15:0]  : 16'd0;
         if (op_ready) k++;
         @(negedge clk);
      end
      chk("two_issued_before_reset", 32'(iss.size() >= 2), 32'd1);
      rst_n = 0;
      op_valid = 0;
      #1;
      chk("midjob_rst_busy", {31'd0, busy}, 32'd0);
      chk("midjob_rst_mac_en", {31'd0, mac_en}, 32'd0);
      chk("midjob_rst_mode", {31'd0, mac_float_int}, 32'd1);
      chk("midjob_rst_outs", {28'd0, op_ready, mac_data_en, res_valid, res_err}, 32'd0);
      chk("midjob_rst_res", res_data, 32'd0);
      @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", {31'd0, busy}, 32'd0);
      src = '{{16'd7, 16'd6}};
      job(1, 1, 0, 0, 0, rd, re);
      chk("post_reset_result", rd, 32'd42);
      post(1);

`ifdef MAC_DRIVER_TIMEOUT_EN
      src = '{{16'd3, 16'd4}, {16'd5, 16'd6}, {16'd7, 16'd8}};
      job(1, 3, 3, 0, 0, rd, re);
      chk("timeout_err", {31'd0, re}, 32'd1);
      chk("timeout_result", rd, 32'd12);
      post(1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mac_driver.md
MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, operand buffer depth in pairs (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, idle-issue cycles before abort.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  job request pulse; sampled only in IDLE.
REQ-006 SHALL have port mode_int  input  1  1: integer job, 0: float job; latched with start.
REQ-007 SHALL have port len  input  8  operand pairs in job; latched with start.
REQ-008 SHALL have ports op_valid/op_ready (input/output, 1) and op_a/op_b (input, 16 each): upstream operand stream.
REQ-009 SHALL have ports mac_float_int, mac_en, mac_data_en (output, 1) and mac_data_a/mac_data_b (output, 16): MAC drive side.
REQ-010 SHALL have ports mac_over (input, 1) and mac_out (input, 32): MAC status and accumulator.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, 32), res_err (output, 1): result stream.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE, CLEAR, RUN, SETTLE, RESULT.
REQ-014 IDLE: start=1 SHALL latch mode_int and len, zero both counters, and go to CLEAR; start in any other state SHALL be ignored.
REQ-015 CLEAR: exactly one cycle, mac_en=0 (zeroes MAC accumulator); next state RUN if len!=0, else SETTLE.
REQ-016 op_ready SHALL be 1 only in CLEAR or RUN, with buffer not full and accepted count < len; a pair is accepted on op_valid&&op_ready.
REQ-017 RUN: mac_en=1; when buffer non-empty, mac_data_en=1 and mac_data_a/b SHALL present the head pair, which pops at that edge; issued count increments.
REQ-018 mac_data_en SHALL be 0 when buffer empty; mac_data_a/b SHALL be 0 whenever mac_data_en=0.
REQ-019 RUN -> SETTLE on the edge issuing pair number len.
REQ-020 SETTLE: mac_en=1, mac_data_en=0; when mac_over=1, SHALL register mac_out into res_data and go to RESULT, else stay.
REQ-021 RESULT: res_valid=1, res_data stable until res_ready=1; on handshake go to IDLE.
REQ-022 mac_float_int SHALL equal latched mode in all non-IDLE states; 1 in IDLE.
REQ-023 Buffer push and pop in the same cycle SHALL both take effect; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 Pairs SHALL be issued in arrival order, none dropped or duplicated; exactly len pairs per job.
REQ-025 Throughput: with op_valid held high, one pair SHALL issue per cycle after first acceptance.
REQ-026 len=0 SHALL produce res_data=0, res_err=0 after CLEAR and SETTLE.

Reset
REQ-027 rst_n=0 SHALL force IDLE, empty buffer, counters 0, res_data=0, res_err=0, and all outputs 0 except mac_float_int=1, including mid-job.
REQ-028 After reset release no job SHALL start without a new start pulse.

Configuration
REQ-029 Macro MAC_DRIVER_TIMEOUT_EN SHALL enable an issue watchdog.
REQ-030 Defined: in RUN, TIMEOUT_CYC consecutive cycles without issue SHALL go to SETTLE, and res_err=1 for that result; counter resets on every issue.
REQ-031 Undefined: no watchdog logic; res_err constant 0; RUN waits indefinitely.

Verification
REQ-032 Int job len=3, pairs (2,3),(4,5),(1,1), MAC model -> mac_float_int=1, three mac_data_en cycles in order, res_data=27, res_err=0.
REQ-033 Float job len=2, op_valid toggling every other cycle -> mac_float_int=0, operands forwarded bit-exact, exactly 2 issues, res_data equals MAC model output.
REQ-034 len=5, op_valid constantly high, FIFO_DEPTH=4, res_ready held 0 for 10 cycles -> one issue per cycle, res_data stable, op_ready=0 after 5 accepts.
REQ-035 len=0 start -> CLEAR, SETTLE, RESULT with res_data=0; start pulse during RESULT ignored.
REQ-036 rst_n asserted after 2 of 4 pairs issued -> immediate IDLE, busy=0, mac_en=0; next job len=1 (7,6) -> res_data=42.
REQ-037 With MAC_DRIVER_TIMEOUT_EN, TIMEOUT_CYC=8, len=3, op_valid drops after 1 pair -> abort after 8 idle cycles, res_err=1, res_data=first product.
